// File: rtl/multicycle_control_fsm.sv
// Main control FSM for the multicycle RV32I core.
// Sequences each instruction through fetch/decode/execute/memory/writeback and
// drives the datapath selects, write strobes and the 2-bit alu_op consumed by
// the ALU decoder.
// Ports:
//   i_clk, i_rst_n      clock, asynchronous active-low reset
//   i_opcode[6:0]       instr[6:0] from the instruction register
//   i_zero              ALU zero flag
//   i_mem_ready         memory access completes this cycle
//   o_pc_write          pc_update | (branch & zero)
//   o_adr_src           memory address select (0 = PC, 1 = ALUOut)
//   o_ir_write          instruction register load strobe
//   o_mem_write         data memory write enable
//   o_reg_write         register file write enable
//   o_result_src[1:0]   result mux (00 ALUOut, 01 Data, 10 ALUResult)
//   o_alu_src_a[1:0]    ALU A mux (00 PC, 01 OldPC, 10 rs1)
//   o_alu_src_b[1:0]    ALU B mux (00 rs2, 01 ImmExt, 10 const 4)
//   o_alu_op[1:0]       00 add, 01 subtract, 10 decode funct fields
//   o_illegal_op        one-cycle pulse in Decode on an unsupported opcode
//   o_state_dbg[3:0]    current state encoding
module multicycle_control_fsm #(
  parameter bit USE_MEM_READY = 1'b1
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic [6:0] i_opcode,
  input  logic       i_zero,
  input  logic       i_mem_ready,
  output logic       o_pc_write,
  output logic       o_adr_src,
  output logic       o_ir_write,
  output logic       o_mem_write,
  output logic       o_reg_write,
  output logic [1:0] o_result_src,
  output logic [1:0] o_alu_src_a,
  output logic [1:0] o_alu_src_b,
  output logic [1:0] o_alu_op,
  output logic       o_illegal_op,
  output logic [3:0] o_state_dbg
);

  localparam int unsigned StateW = 4;
  localparam int unsigned OpW    = 7;

  localparam logic [OpW-1:0] OpLw   = 7'b0000011;
  localparam logic [OpW-1:0] OpSw   = 7'b0100011;
  localparam logic [OpW-1:0] OpR    = 7'b0110011;
  localparam logic [OpW-1:0] OpI    = 7'b0010011;
  localparam logic [OpW-1:0] OpBeq  = 7'b1100011;
  localparam logic [OpW-1:0] OpJal  = 7'b1101111;

  typedef enum logic [StateW-1:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECR    = 4'd6,
    S_EXECI    = 4'd7,
    S_ALUWB    = 4'd8,
    S_BEQ      = 4'd9,
    S_JAL      = 4'd10
  } state_t;

  state_t     r_state;
  state_t     w_next;
  logic       w_mem_ready;
  logic       w_pc_update;
  logic       w_branch;
  logic       w_ir_write;
  logic       w_mem_write;
  logic       w_reg_write;
  logic       w_illegal;

  // Ready is tied high when the memory never stalls.
  assign w_mem_ready = USE_MEM_READY ? i_mem_ready : 1'b1;

  // State register.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_state <= S_FETCH;
    else          r_state <= w_next;
  end

  // Next-state and per-state output decode.
  always_comb begin
    w_next       = S_FETCH;
    w_pc_update  = 1'b0;
    w_branch     = 1'b0;
    w_ir_write   = 1'b0;
    w_mem_write  = 1'b0;
    w_reg_write  = 1'b0;
    w_illegal    = 1'b0;
    o_adr_src    = 1'b0;
    o_result_src = 2'b00;
    o_alu_src_a  = 2'b00;
    o_alu_src_b  = 2'b00;
    o_alu_op     = 2'b00;
    case (r_state)
      S_FETCH: begin
        o_alu_src_b  = 2'b10;
        o_result_src = 2'b10;
        w_ir_write   = w_mem_ready;
        w_pc_update  = w_mem_ready;
        w_next       = w_mem_ready ? S_DECODE : S_FETCH;
      end
      S_DECODE: begin
        // Precompute the branch target while the opcode is decoded.
        o_alu_src_a = 2'b01;
        o_alu_src_b = 2'b01;
        case (i_opcode)
          OpLw, OpSw: w_next = S_MEMADR;
          OpR:        w_next = S_EXECR;
          OpI:        w_next = S_EXECI;
          OpBeq:      w_next = S_BEQ;
          OpJal:      w_next = S_JAL;
          default: begin
            w_next    = S_FETCH;
            w_illegal = 1'b1;
          end
        endcase
      end
      S_MEMADR: begin
        o_alu_src_a = 2'b10;
        o_alu_src_b = 2'b01;
        // opcode[5] separates sw (1) from lw (0).
        w_next      = i_opcode[5] ? S_MEMWRITE : S_MEMREAD;
      end
      S_MEMREAD: begin
        o_adr_src = 1'b1;
        w_next    = w_mem_ready ? S_MEMWB : S_MEMREAD;
      end
      S_MEMWB: begin
        o_result_src = 2'b01;
        w_reg_write  = 1'b1;
        w_next       = S_FETCH;
      end
      S_MEMWRITE: begin
        o_adr_src   = 1'b1;
        w_mem_write = 1'b1;
        w_next      = w_mem_ready ? S_FETCH : S_MEMWRITE;
      end
      S_EXECR: begin
        o_alu_src_a = 2'b10;
        o_alu_op    = 2'b10;
        w_next      = S_ALUWB;
      end
      S_EXECI: begin
        o_alu_src_a = 2'b10;
        o_alu_src_b = 2'b01;
        o_alu_op    = 2'b10;
        w_next      = S_ALUWB;
      end
      S_ALUWB: begin
        w_reg_write = 1'b1;
        w_next      = S_FETCH;
      end
      S_BEQ: begin
        o_alu_src_a = 2'b10;
        o_alu_op    = 2'b01;
        w_branch    = 1'b1;
        w_next      = S_FETCH;
      end
      S_JAL: begin
        o_alu_src_a = 2'b01;
        o_alu_src_b = 2'b10;
        w_pc_update = 1'b1;
        w_next      = S_ALUWB;
      end
      default: w_next = S_FETCH;
    endcase
  end

  // Strobes are forced low for the whole time reset is held, so a reset
  // landing mid-instruction cannot leak a partial write.
  assign o_pc_write   = i_rst_n & (w_pc_update | (w_branch & i_zero));
  assign o_ir_write   = i_rst_n & w_ir_write;
  assign o_mem_write  = i_rst_n & w_mem_write;
  assign o_reg_write  = i_rst_n & w_reg_write;
  assign o_illegal_op = i_rst_n & w_illegal;
  assign o_state_dbg  = StateW'(r_state);

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Self-checking bench for multicycle_control_fsm: every cycle the expected
// output vector is pushed to a scoreboard as stimulus is driven, then popped
// and compared against the DUT outputs.
module tb_multicycle_control_fsm;

  logic       clk;
  logic       rst_n;
  logic [6:0] opcode;
  logic       zero;
  logic       mem_ready;
  logic       pc_write, adr_src, ir_write, mem_write, reg_write, illegal_op;
  logic [1:0] result_src, alu_src_a, alu_src_b, alu_op;
  logic [3:0] state_dbg;
  logic [17:0] dut_vec;

  logic [17:0] sb_q[$];
  int n_tests = 0;
  int n_fail  = 0;

  multicycle_control_fsm #(.USE_MEM_READY(1'b1)) u_dut (
    .i_clk        (clk),
    .i_rst_n      (rst_n),
    .i_opcode     (opcode),
    .i_zero       (zero),
    .i_mem_ready  (mem_ready),
    .o_pc_write   (pc_write),
    .o_adr_src    (adr_src),
    .o_ir_write   (ir_write),
    .o_mem_write  (mem_write),
    .o_reg_write  (reg_write),
    .o_result_src (result_src),
    .o_alu_src_a  (alu_src_a),
    .o_alu_src_b  (alu_src_b),
    .o_alu_op     (alu_op),
    .o_illegal_op (illegal_op),
    .o_state_dbg  (state_dbg)
  );

  assign dut_vec = {state_dbg, pc_write, adr_src, ir_write, mem_write, reg_write,
                    result_src, alu_src_a, alu_src_b, alu_op, illegal_op};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [17:0] got, input logic [17:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got st=%0d pcw=%b adr=%b irw=%b mw=%b rw=%b rs=%b a=%b b=%b op=%b ill=%b, expected st=%0d pcw=%b adr=%b irw=%b mw=%b rw=%b rs=%b a=%b b=%b op=%b ill=%b",
               tag, got[17:14], got[13], got[12], got[11], got[10], got[9], got[8:7],
               got[6:5], got[4:3], got[2:1], got[0], exp[17:14], exp[13], exp[12],
               exp[11], exp[10], exp[9], exp[8:7], exp[6:5], exp[4:3], exp[2:1], exp[0]);
    end
  endtask

  // Reference output table, one row per state.
  function automatic logic [17:0] exp_vec(input logic [3:0] st, input logic [6:0] opc,
                                          input logic z, input logic rdy, input logic rstn);
    logic pcw, adr, irw, mw, rw, ill;
    logic [1:0] rs, a, b, op;
    pcw = 0; adr = 0; irw = 0; mw = 0; rw = 0; ill = 0;
    rs = 2'b00; a = 2'b00; b = 2'b00; op = 2'b00;
    case (st)
      4'd0:  begin b = 2'b10; rs = 2'b10; irw = rdy; pcw = rdy; end
      4'd1:  begin
        a = 2'b01; b = 2'b01;
        ill = !(opc == 7'h03 || opc == 7'h23 || opc == 7'h33 ||
                opc == 7'h13 || opc == 7'h63 || opc == 7'h6F);
      end
      4'd2:  begin a = 2'b10; b = 2'b01; end
      4'd3:  adr = 1;
      4'd4:  begin rs = 2'b01; rw = 1; end
      4'd5:  begin adr = 1; mw = 1; end
      4'd6:  begin a = 2'b10; b = 2'b00; op = 2'b10; end
      4'd7:  begin a = 2'b10; b = 2'b01; op = 2'b10; end
      4'd8:  rw = 1;
      4'd9:  begin a = 2'b10; op = 2'b01; pcw = z; end
      4'd10: begin a = 2'b01; b = 2'b10; pcw = 1; end
      default: ;
    endcase
    if (!rstn) begin pcw = 0; irw = 0; mw = 0; rw = 0; ill = 0; end
    return {st, pcw, adr, irw, mw, rw, rs, a, b, op, ill};
  endfunction

  // One cycle: drive inputs at the falling edge, push the expectation,
  // pop and compare shortly after, then advance to the next falling edge.
  task automatic cyc(input string tag, input logic [3:0] st, input logic [6:0] opc,
                     input logic z, input logic rdy);
    opcode    = opc;
    zero      = z;
    mem_ready = rdy;
    sb_q.push_back(exp_vec(st, opc, z, rdy, rst_n));
    #1;
    check(tag, dut_vec, sb_q.pop_front());
    @(negedge clk);
  endtask

  // Run n cycles; seq holds the expected states LSB-nibble first, rdy the
  // mem_ready value applied in each cycle.
  task automatic run(input string name, input logic [6:0] opc, input logic z,
                     input int n, input logic [31:0] seq, input logic [7:0] rdy);
    for (int i = 0; i < n; i++)
      cyc($sformatf("%s_c%0d", name, i), seq[4*i +: 4], opc, z, rdy[i]);
  endtask

  initial begin
    rst_n = 1'b0; opcode = 7'h00; zero = 1'b0; mem_ready = 1'b1;
    @(negedge clk);
    cyc("reset_hold", 4'd0, 7'h00, 1'b0, 1'b1);
    rst_n = 1'b1;

    run("lw",      7'h03, 1'b0, 5, 32'h0004_3210, 8'h1F);
    run("sw",      7'h23, 1'b0, 4, 32'h0000_5210, 8'h0F);
    run("rtype",   7'h33, 1'b0, 4, 32'h0000_8610, 8'h0F);
    run("itype",   7'h13, 1'b0, 4, 32'h0000_8710, 8'h0F);
    run("jal",     7'h6F, 1'b0, 4, 32'h0000_8A10, 8'h0F);
    run("beq_z1",  7'h63, 1'b1, 3, 32'h0000_0910, 8'h07);
    run("beq_z0",  7'h63, 1'b0, 3, 32'h0000_0910, 8'h07);
    run("sw_wait", 7'h23, 1'b0, 6, 32'h0055_5210, 8'b0010_0111);
    run("lw_wait", 7'h03, 1'b0, 7, 32'h0433_2100, 8'b0110_1110);
    run("illegal", 7'h7F, 1'b0, 2, 32'h0000_0010, 8'h03);

    // Abort an R-type in EXECR with reset; no strobes while reset is low.
    run("rt_abort", 7'h33, 1'b0, 3, 32'h0000_0610, 8'h07);
    rst_n = 1'b0;
    cyc("reset_mid0", 4'd0, 7'h33, 1'b0, 1'b1);
    cyc("reset_mid1", 4'd0, 7'h33, 1'b0, 1'b1);
    rst_n = 1'b1;
    run("post_rst_lw", 7'h03, 1'b0, 5, 32'h0004_3210, 8'h1F);
    cyc("end_fetch", 4'd0, 7'h00, 1'b0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
